// File: rtl/pixel_filter_pkg.sv
// Shared types and helpers for the BPM-driven pixel brightness filter.
//   filter_mode_t  : per-channel operation selector
//   bpm_to_target  : clamps a BPM reading and scales it to a brightness target
//   ramp           : moves a brightness value toward a target by a bounded step
package pixel_filter_pkg;

  typedef enum logic [1:0] {
    FM_THRESH = 2'd0,
    FM_AVG    = 2'd1,
    FM_SCALE  = 2'd2,
    FM_SATADD = 2'd3
  } filter_mode_t;

  // Clamp bpm into [min_bpm, max_bpm], multiply by the Q8 scale and saturate at maxv.
  // The product is formed at 64 bits so no parameter combination can overflow it.
  function automatic logic [31:0] bpm_to_target(input logic [31:0] bpm,
                                                input logic [31:0] min_bpm,
                                                input logic [31:0] max_bpm,
                                                input logic [31:0] step_size,
                                                input logic [31:0] maxv);
    logic [31:0] bpm_c;
    logic [63:0] prod;
    logic [63:0] scaled;
    if (bpm < min_bpm) begin
      bpm_c = min_bpm;
    end else if (bpm > max_bpm) begin
      bpm_c = max_bpm;
    end else begin
      bpm_c = bpm;
    end
    prod   = {32'd0, step_size} * {32'd0, bpm_c};
    scaled = prod >> 8;
    if (scaled > {32'd0, maxv}) begin
      return maxv;
    end else begin
      return scaled[31:0];
    end
  endfunction

  // Step cur toward target by at most step; differences are compared rather than
  // sums so the result never wraps.
  function automatic logic [31:0] ramp(input logic [31:0] cur,
                                       input logic [31:0] target,
                                       input logic [31:0] step);
    if (cur < target) begin
      if ((target - cur) > step) begin
        return cur + step;
      end else begin
        return target;
      end
    end else if (cur > target) begin
      if ((cur - target) > step) begin
        return cur - step;
      end else begin
        return target;
      end
    end else begin
      return cur;
    end
  endfunction

endpackage

// File: rtl/pixel_channel_op.sv
// Combinational brightness operation on a single colour channel.
//   p    : channel value
//   b    : brightness snapshot for this beat
//   mode : filter_mode_t encoding (threshold / average / scale / saturating add)
//   en   : 0 passes p through untouched
//   q    : filtered channel value
module pixel_channel_op
  import pixel_filter_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] p,
  input  logic [BITS-1:0] b,
  input  logic [1:0]      mode,
  input  logic            en,
  output logic [BITS-1:0] q
);

  logic [BITS:0]     sum_s;
  logic [2*BITS-1:0] prod_s;
  logic              unused_s;

  assign sum_s  = {1'b0, p} + {1'b0, b};
  assign prod_s = {{BITS{1'b0}}, p} * {{BITS{1'b0}}, b};
  // The scale result keeps only the upper half of the product.
  assign unused_s = ^prod_s[BITS-1:0];

  // Select the channel result for the active mode.
  always_comb begin
    if (!en) begin
      q = p;
    end else begin
      case (filter_mode_t'(mode))
        FM_THRESH: begin
          if (p <= b) begin
            q = {BITS{1'b0}};
          end else begin
            q = p;
          end
        end
        FM_AVG:    q = sum_s[BITS:1];
        FM_SCALE:  q = prod_s[2*BITS-1:BITS];
        FM_SATADD: begin
          if (sum_s[BITS]) begin
            q = {BITS{1'b1}};
          end else begin
            q = sum_s[BITS-1:0];
          end
        end
        default:   q = p;
      endcase
    end
  end

endmodule

// File: rtl/pixel_bpm_filter_pipe.sv
// Multi-channel, two-stage pipelined BPM-driven brightness filter.
//   clk, reset          : clock, asynchronous active-high reset
//   pix_in/sop_in/valid_in/ready_out  : upstream beat (channel 0 in LSBs) + handshake
//   filter_enable/filter_mode/bpm_estimate : configuration, taken on sop beats only
//   pix_out/sop_out/valid_out/ready_in : downstream beat + handshake
//   brightness          : brightness currently applied (b_cur)
module pixel_bpm_filter_pipe
  import pixel_filter_pkg::*;
#(
  parameter int CHANNELS  = 3,
  parameter int BITS      = 8,
  parameter int MIN_BPM   = 40,
  parameter int MAX_BPM   = 200,
  parameter int STEP_SIZE = ((2**BITS) * 256) / MAX_BPM,
  parameter int RAMP_STEP = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*BITS-1:0]     pix_in,
  input  logic                         sop_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic                         filter_enable,
  input  logic [1:0]                   filter_mode,
  input  logic [$clog2(MAX_BPM+1)-1:0] bpm_estimate,
  output logic [CHANNELS*BITS-1:0]     pix_out,
  output logic                         sop_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic [BITS-1:0]              brightness
);

  localparam int W    = CHANNELS * BITS;
  localparam int MAXV = (2**BITS) - 1;

  logic [BITS-1:0] b_cur_r;
  logic            cfg_en_r;
  logic [1:0]      cfg_mode_r;

  logic            v1_r, sop1_r, en1_r;
  logic [W-1:0]    pix1_r;
  logic [BITS-1:0] b1_r;
  logic [1:0]      mode1_r;

  logic            v2_r, sop2_r;
  logic [W-1:0]    pix2_r;

  logic            en1_s, en2_s, accept_s;
  logic [31:0]     target_s, ramp_s;
  logic [BITS-1:0] b_snap_s;
  logic            en_snap_s;
  logic [1:0]      mode_snap_s;
  logic [W-1:0]    op_pix_s;
  logic            unused_s;

  // A stage may load when it is empty or its contents are leaving this cycle.
  assign en2_s     = !v2_r || ready_in;
  assign en1_s     = !v1_r || en2_s;
  assign ready_out = en1_s;
  assign accept_s  = valid_in && en1_s;
  assign unused_s  = ^ramp_s[31:BITS];

  // Brightness and configuration snapshot for the beat being accepted; a sop beat
  // sees its own freshly ramped brightness and newly sampled configuration.
  always_comb begin
    target_s = bpm_to_target(32'(bpm_estimate), 32'(MIN_BPM), 32'(MAX_BPM),
                             32'(STEP_SIZE), 32'(MAXV));
    ramp_s   = ramp(32'(b_cur_r), target_s, 32'(RAMP_STEP));
    if (accept_s && sop_in) begin
      b_snap_s    = ramp_s[BITS-1:0];
      en_snap_s   = filter_enable;
      mode_snap_s = filter_mode;
    end else begin
      b_snap_s    = b_cur_r;
      en_snap_s   = cfg_en_r;
      mode_snap_s = cfg_mode_r;
    end
  end

  // Frame-level state: brightness and configuration change only on accepted sop beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_cur_r    <= {BITS{1'b0}};
      cfg_en_r   <= 1'b0;
      cfg_mode_r <= 2'd0;
    end else begin
      b_cur_r    <= b_snap_s;
      cfg_en_r   <= en_snap_s;
      cfg_mode_r <= mode_snap_s;
    end
  end

  // Stage 1: capture pixel, sop and the per-beat brightness/configuration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_r    <= 1'b0;
      sop1_r  <= 1'b0;
      pix1_r  <= {W{1'b0}};
      b1_r    <= {BITS{1'b0}};
      en1_r   <= 1'b0;
      mode1_r <= 2'd0;
    end else if (en1_s) begin
      v1_r    <= valid_in;
      sop1_r  <= sop_in && valid_in;
      pix1_r  <= pix_in;
      b1_r    <= b_snap_s;
      en1_r   <= en_snap_s;
      mode1_r <= mode_snap_s;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    pixel_channel_op #(.BITS(BITS)) u_op (
      .p    (pix1_r[c*BITS +: BITS]),
      .b    (b1_r),
      .mode (mode1_r),
      .en   (en1_r),
      .q    (op_pix_s[c*BITS +: BITS])
    );
  end

  // Stage 2: register the filtered result; holds while downstream stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2_r   <= 1'b0;
      sop2_r <= 1'b0;
      pix2_r <= {W{1'b0}};
    end else if (en2_s) begin
      v2_r   <= v1_r;
      sop2_r <= sop1_r;
      pix2_r <= op_pix_s;
    end
  end

  assign pix_out    = pix2_r;
  assign sop_out    = sop2_r;
  assign valid_out  = v2_r;
  assign brightness = b_cur_r;

endmodule
